bin_to_sseg_digits: RTL and testbench
=====================================

// Module: bin_to_sseg_digits
// PURPOSE
//  Sequential binary-to-4-digit decimal converter that feeds the 4-digit display multiplexer.
//  Captures a W-bit unsigned value on a start/ready handshake and converts it to BCD by
//  double-dabble, one bit per clock. Encodes each BCD digit to an active-low 7-seg pattern and
//  registers the four patterns as dig0..dig3, which connect directly to the mux in0..in3.
//  Values above 9999 show "----" and assert ovf.
// PARAMETERS
//  W  14  binary input width; legal range 4..14 (W<=13 can never overflow)
// PORTS
//  clk      in   1   clock
//  rst      in   1   reset, asynchronous, active-high
//  start    in   1   conversion request; sampled only while ready=1
//  bin      in   W   unsigned value, captured with start
//  dp_sel   in   4   decimal-point enable per digit (bit i -> dig i), captured with start
//  ready    out  1   high in IDLE only
//  done     out  1   1-cycle pulse: new dig0..dig3/bcd/ovf are valid
//  ovf      out  1   last captured value > 9999
//  bcd      out  16  {thousands,hundreds,tens,units}; 16'h0000 when ovf
//  dig0..3  out  8   {dp,g,f,e,d,c,b,a}, active low; dig0 = units (rightmost)
// BEHAVIOUR
//  Reset: IDLE state; ready=1, done=0, ovf=0, bcd=16'h0000, dig0..dig3=8'hFF (blank).
//  FSM: IDLE -> CONV -> DONE -> IDLE.
//   - IDLE: start=1 captures bin, dp_sel; clears the 16-bit BCD accumulator; loads the bit counter with W.
//   - CONV: runs exactly W cycles. Each cycle, add 3 to every BCD nibble >=5, then shift
//     {bcd,bin_shift} left 1. Use a 17-bit accumulator so 10000..16383 is detected.
//   - DONE: runs 1 cycle. The output registers update on the edge that enters DONE, and done=1 for this cycle.
//  Latency: start accepted at edge k -> done high in the cycle after edge k+W; next start is accepted at edge k+W+2.
//  start while ready=0: ignored, not queued. start held high: a new conversion every W+2 cycles.
//  Outputs hold their value between conversions. They change only on entry to DONE or on reset.
//  Segment codes (dp off): 0=C0 1=F9 2=A4 3=B0 4=99 5=92 6=82 7=F8 8=80 9=90.
//   - Dash = BF. Blank = FF.
//   - dp: bit7 cleared when the captured dp_sel[i]=1. This applies to digits, dashes and blanks.
//  Overflow (value>=10000): ovf=1, all four digits dash, bcd=0.
//   - ovf is cleared by the next in-range conversion.
//  Reset mid-CONV/DONE: conversion discarded, no done pulse, all outputs return to reset values.
// CONFIGURATION
//  LEADING_ZERO_BLANK_EN defined:
//   - Leading zero digits (dig3 down to dig1) that precede the first nonzero digit are blanked to FF.
//   - dig0 is never blanked. dp on a blanked digit still follows dp_sel.
//   - Overflow dashes are unaffected. bcd is unaffected.
//  Not defined: all four digits are always shown, including leading zeros.
// TESTING (W=14)
//  1. bin=1234, dp_sel=0 -> done pulses 15 cycles after start. bcd=16'h1234.
//     dig3..0 = F9,A4,B0,99. ovf=0.
//  2. bin=0, dp_sel=4'b0100 -> dig3..0 = C0,40,C0,C0. No macro: zeros shown.
//     With macro: dig3..0 = FF,7F,FF,C0.
//  3. bin=9999 -> dig3..0 = 90 x4, ovf=0. Then bin=10000 -> dig3..0 = BF x4, ovf=1, bcd=0.
//  4. start pulsed twice, 3 cycles apart -> exactly one done. The second bin is not captured.
//     ready low for 15 cycles.
//  5. rst asserted at CONV cycle 6 after showing 1234 -> dig=FF x4, done never pulses.
//     ready=1 after rst release.
//  6. With macro: bin=7 -> dig3..0 = FF,FF,FF,F8. Then bin=1005 -> F9,C0,C0,92 (inner zeros kept).

Source files
------------

// File: rtl/bin_to_sseg_digits.sv
// ---------------------------------------------------------------------------
// bin_to_sseg_digits
// Sequential binary -> 4-digit decimal converter for the 4-digit display mux.
// A W-bit unsigned value is captured on a start/ready handshake. It is then
// converted to BCD by double-dabble, one bit per clock. Each BCD digit is
// encoded to an active-low 7-segment pattern {dp,g,f,e,d,c,b,a}.
// Values above 9999 show "----" and assert ovf.
//
// Optional feature: define LEADING_ZERO_BLANK_EN to blank the leading zero
// digits dig3..dig1. dig0 is never blanked.
//
// Ports
//   clk, rst       clock; asynchronous active-high reset
//   start          conversion request, sampled only while ready=1
//   bin[W-1:0]     unsigned value, captured with start
//   dp_sel[3:0]    decimal-point enable per digit, captured with start
//   ready          high while idle
//   done           1-cycle pulse when new outputs are valid
//   ovf            last captured value > 9999
//   bcd[15:0]      {thousands,hundreds,tens,units}; zero on overflow
//   dig0..dig3     segment patterns, dig0 = units (rightmost)
// ---------------------------------------------------------------------------
module bin_to_sseg_digits #(
   parameter int W = 14
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [W-1:0] bin,
   input  logic [3:0]   dp_sel,
   output logic         ready,
   output logic         done,
   output logic         ovf,
   output logic [15:0]  bcd,
   output logic [7:0]   dig0,
   output logic [7:0]   dig1,
   output logic [7:0]   dig2,
   output logic [7:0]   dig3
);

   localparam int CW = $clog2(W + 1);

   typedef enum logic [1:0] {S_IDLE, S_CONV, S_DONE} state_t;

   state_t            state_reg, state_next;
   logic [W-1:0]      shift_reg, shift_next;
   logic [15:0]       acc_reg, acc_next;
   logic [CW-1:0]     cnt_reg, cnt_next;
   logic [3:0]        dp_reg, dp_next;
   logic              load_out;

   logic [3:0][7:0]   dig_reg;
   logic [3:0][7:0]   dig_next;
   logic [15:0]       bcd_reg;
   logic              ovf_reg;

   // One double-dabble step. The adjusted accumulator is shifted into 17 bits,
   // so on the final step bit 16 marks a ten-thousands digit (value >= 10000).
   logic [15:0]       adj;
   logic [16:0]       acc_step;
   logic [3:0][3:0]   bcd_digit;
   logic [3:0]        lead_zero;

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_adj
         assign adj[4*gi +: 4] = (acc_reg[4*gi +: 4] >= 4'd5) ? acc_reg[4*gi +: 4] + 4'd3
                                                              : acc_reg[4*gi +: 4];
         assign bcd_digit[gi]  = acc_step[4*gi +: 4];
      end
   endgenerate

   assign acc_step = {adj, shift_reg[W-1]};

   // A digit is blanked only while every higher digit is also zero.
`ifdef LEADING_ZERO_BLANK_EN
   assign lead_zero[3] = (bcd_digit[3] == 4'd0);
   assign lead_zero[2] = lead_zero[3] && (bcd_digit[2] == 4'd0);
   assign lead_zero[1] = lead_zero[2] && (bcd_digit[1] == 4'd0);
   assign lead_zero[0] = 1'b0;
`else
   assign lead_zero = 4'b0000;
`endif

   // The segment field {g..a} is active low. The dp bit is taken from the
   // captured dp_sel.
   function automatic logic [6:0] seg7(input logic [3:0] d);
      case (d)
         4'd0:    seg7 = 7'h40;
         4'd1:    seg7 = 7'h79;
         4'd2:    seg7 = 7'h24;
         4'd3:    seg7 = 7'h30;
         4'd4:    seg7 = 7'h19;
         4'd5:    seg7 = 7'h12;
         4'd6:    seg7 = 7'h02;
         4'd7:    seg7 = 7'h78;
         4'd8:    seg7 = 7'h00;
         4'd9:    seg7 = 7'h10;
         default: seg7 = 7'h7F;
      endcase
   endfunction

   generate
      for (gi = 0; gi < 4; gi++) begin : g_enc
         assign dig_next[gi] = {~dp_reg[gi],
                                acc_step[16]  ? 7'h3F :      // dash
                                lead_zero[gi] ? 7'h7F :      // blank
                                                seg7(bcd_digit[gi])};
      end
   endgenerate

   always_comb begin
      state_next = state_reg;
      shift_next = shift_reg;
      acc_next   = acc_reg;
      cnt_next   = cnt_reg;
      dp_next    = dp_reg;
      load_out   = 1'b0;
      case (state_reg)
         S_IDLE: begin
            if (start) begin
               shift_next = bin;
               dp_next    = dp_sel;
               acc_next   = 16'h0000;
               cnt_next   = CW'(W);
               state_next = S_CONV;
            end
         end
         S_CONV: begin
            acc_next   = acc_step[15:0];
            shift_next = shift_reg << 1;
            cnt_next   = cnt_reg - CW'(1);
            if (cnt_reg == CW'(1)) begin
               // The final step result goes straight into the output registers.
               load_out   = 1'b1;
               state_next = S_DONE;
            end
         end
         S_DONE:  state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= S_IDLE;
         shift_reg <= '0;
         acc_reg   <= '0;
         cnt_reg   <= '0;
         dp_reg    <= '0;
         dig_reg   <= {4{8'hFF}};
         bcd_reg   <= 16'h0000;
         ovf_reg   <= 1'b0;
      end else begin
         state_reg <= state_next;
         shift_reg <= shift_next;
         acc_reg   <= acc_next;
         cnt_reg   <= cnt_next;
         dp_reg    <= dp_next;
         if (load_out) begin
            dig_reg <= dig_next;
            bcd_reg <= acc_step[16] ? 16'h0000 : acc_step[15:0];
            ovf_reg <= acc_step[16];
         end
      end
   end

   assign ready = (state_reg == S_IDLE);
   assign done  = (state_reg == S_DONE);
   assign ovf   = ovf_reg;
   assign bcd   = bcd_reg;
   assign dig0  = dig_reg[0];
   assign dig1  = dig_reg[1];
   assign dig2  = dig_reg[2];
   assign dig3  = dig_reg[3];

endmodule

// File: tb/tb_bin_to_sseg_digits.sv
// ---------------------------------------------------------------------------
// tb_bin_to_sseg_digits
// Self-checking bench for bin_to_sseg_digits with W=14. It uses directed
// corner values plus random values. Expected results come from a decimal
// model of the display rules.
// ---------------------------------------------------------------------------
module tb_bin_to_sseg_digits;

   localparam int W = 14;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         start = 1'b0;
   logic [W-1:0] bin = '0;
   logic [3:0]   dp_sel = 4'b0000;
   logic         ready, done, ovf;
   logic [15:0]  bcd;
   logic [7:0]   dig0, dig1, dig2, dig3;

   int n_checks = 0;
   int n_pass   = 0;

   logic [7:0] seg_tab [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

   bin_to_sseg_digits #(.W(W)) dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .bin    (bin),
      .dp_sel (dp_sel),
      .ready  (ready),
      .done   (done),
      .ovf    (ovf),
      .bcd    (bcd),
      .dig0   (dig0),
      .dig1   (dig1),
      .dig2   (dig2),
      .dig3   (dig3)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   function automatic int dec_digit(input int v, input int i);
      int p = 1;
      for (int k = 0; k < i; k++) p = p * 10;
      return (v / p) % 10;
   endfunction

   function automatic logic [7:0] model_dig(input int v, input logic [3:0] dp, input int i);
      logic [7:0] code;
      bit         lead;
      if (v > 9999) code = 8'hBF;
      else begin
         code = seg_tab[dec_digit(v, i)];
`ifdef LEADING_ZERO_BLANK_EN
         lead = 1'b1;
         for (int k = 3; k >= i; k--) if (dec_digit(v, k) != 0) lead = 1'b0;
         if (i > 0 && lead) code = 8'hFF;
`else
         lead = 1'b0;
         if (lead) code = 8'hFF;
`endif
      end
      if (dp[i]) code[7] = 1'b0;
      return code;
   endfunction

   function automatic logic [15:0] model_bcd(input int v);
      if (v > 9999) return 16'h0000;
      return 16'(dec_digit(v, 3) * 4096 + dec_digit(v, 2) * 256 + dec_digit(v, 1) * 16 + dec_digit(v, 0));
   endfunction

   task automatic check_outputs(input int v, input logic [3:0] dp);
      logic [3:0][7:0] obs;
      obs = {dig3, dig2, dig1, dig0};
      chk("bcd", 32'(bcd), 32'(model_bcd(v)));
      chk("ovf", 32'(ovf), 32'(v > 9999));
      for (int i = 0; i < 4; i++)
         chk($sformatf("dig%0d", i), 32'(obs[i]), 32'(model_dig(v, dp, i)));
   endtask

   // Runs one conversion. It checks the latency, the ready-low time, the
   // results and the single-cycle done pulse.
   task automatic do_conv(input int v, input logic [3:0] dp);
      int lat, rlow;
      bin = W'(v); dp_sel = dp; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      lat = 0;
      rlow = ready ? 0 : 1;
      while (!done && lat < 100) begin
         @(posedge clk); #1;
         lat++;
         if (!ready) rlow++;
      end
      chk("latency", 32'(lat), 32'(W));
      chk("ready_low", 32'(rlow), 32'(W + 1));
      check_outputs(v, dp);
      $display("conv bin=%0d dp=%b -> bcd=%h ovf=%b dig3..0=%h %h %h %h lat=%0d",
               v, dp, bcd, ovf, dig3, dig2, dig1, dig0, lat);
      @(posedge clk); #1;
      chk("done_pulse", 32'(done), 32'(0));
      chk("ready_back", 32'(ready), 32'(1));
   endtask

   initial begin
      int v, dones, rlow, gap;
      int dir_vals [10] = '{1234, 0, 9999, 10000, 16383, 7, 1005, 1, 10, 9000};
      logic [3:0] dir_dp [10] = '{4'b0000, 4'b0100, 4'b0000, 4'b0000, 4'b1111,
                                  4'b0000, 4'b0000, 4'b1000, 4'b0011, 4'b0001};

      // Reset state
      #12;
      chk("rst_ready", 32'(ready), 32'(1));
      chk("rst_done",  32'(done),  32'(0));
      chk("rst_ovf",   32'(ovf),   32'(0));
      chk("rst_bcd",   32'(bcd),   32'(0));
      chk("rst_digs",  32'({dig3, dig2, dig1, dig0}), 32'hFFFFFFFF);
      @(posedge clk); #1; rst = 1'b0;
      @(posedge clk); #1;

      // Directed values
      for (int i = 0; i < 10; i++) do_conv(dir_vals[i], dir_dp[i]);

      // Fixed segment anchors for 1234
      do_conv(1234, 4'b0000);
      chk("anchor_1234", 32'({dig3, dig2, dig1, dig0}), 32'hF9A4B099);

      // Randomised values
      for (int i = 0; i < 25; i++) begin
         v = int'($urandom_range(0, 16383));
         do_conv(v, 4'($urandom_range(0, 15)));
      end

      // A second start while busy is ignored
      bin = W'(1111); dp_sel = 4'b0000; start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
      dones = 0; rlow = ready ? 0 : 1;
      for (int c = 1; c <= W + 10; c++) begin
         if (c == 2) begin bin = W'(2222); start = 1'b1; end
         if (c == 3) start = 1'b0;
         @(posedge clk); #1;
         if (done) dones++;
         if (!ready) rlow++;
      end
      chk("busy_dones", 32'(dones), 32'(1));
      chk("busy_ready_low", 32'(rlow), 32'(W + 1));
      chk("busy_bcd", 32'(bcd), 32'(model_bcd(1111)));
      $display("busy start test: dones=%0d bcd=%h", dones, bcd);

      // start held high: a new conversion every W+2 cycles
      bin = W'(4321); dp_sel = 4'b0010; start = 1'b1;
      gap = 0;
      while (!done && gap < 100) begin @(posedge clk); #1; gap++; end
      gap = 0;
      @(posedge clk); #1;
      gap = 1;
      while (!done && gap < 100) begin @(posedge clk); #1; gap++; end
      start = 1'b0;
      chk("held_period", 32'(gap), 32'(W + 2));
      check_outputs(4321, 4'b0010);
      $display("held start test: period=%0d", gap);
      @(posedge clk); #1;
      @(posedge clk); #1;

      // Reset in the middle of a conversion
      do_conv(1234, 4'b0000);
      bin = W'(5678); start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
      repeat (6) @(posedge clk);
      #2 rst = 1'b1;
      #1;
      chk("midrst_digs",  32'({dig3, dig2, dig1, dig0}), 32'hFFFFFFFF);
      chk("midrst_bcd",   32'(bcd),   32'(0));
      chk("midrst_ready", 32'(ready), 32'(1));
      @(posedge clk); #1; rst = 1'b0;
      dones = 0;
      for (int c = 0; c < W + 4; c++) begin
         @(posedge clk); #1;
         if (done) dones++;
      end
      chk("midrst_dones", 32'(dones), 32'(0));
      chk("midrst_ready_after", 32'(ready), 32'(1));
      $display("mid-conversion reset test: dones=%0d", dones);

      // Normal operation after reset
      do_conv(42, 4'b0001);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
